// File: rtl/ascon_pkg.sv
// Shared Ascon types.
// The permutation state is five 64-bit words, s[0] first.
package ascon_pkg;

    typedef logic [4:0][63:0] t_state_array;

endpackage

// File: rtl/sbox.sv
// Ascon 5-bit S-box, bitsliced form.
// Bit 4 of i_x/o_y carries word 0 of the state.
module sbox (
    input  logic [4:0] i_x,
    output logic [4:0] o_y
);

    logic a0, a1, a2, a3, a4;
    logic b0, b1, b2, b3, b4;

    assign a0 = i_x[4] ^ i_x[0];
    assign a1 = i_x[3];
    assign a2 = i_x[2] ^ i_x[3];
    assign a3 = i_x[1];
    assign a4 = i_x[0] ^ i_x[1];

    // chi-like nonlinear layer
    assign b0 = a0 ^ (~a1 & a2);
    assign b1 = a1 ^ (~a2 & a3);
    assign b2 = a2 ^ (~a3 & a4);
    assign b3 = a3 ^ (~a4 & a0);
    assign b4 = a4 ^ (~a0 & a1);

    assign o_y = {b0 ^ b4, b1 ^ b0, ~b2, b3 ^ b2, b4};

endmodule

// File: rtl/substitution_layer_iter.sv
// Iterative Ascon substitution layer.
// Applies G_NUM_SBOXES S-boxes per cycle over 64 columns.
module substitution_layer_iter
    import ascon_pkg::*;
#(
    parameter int G_NUM_SBOXES = 8,
    parameter bit G_OUT_REG    = 1'b1
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_valid,
    output logic         o_ready,
    input  t_state_array i_state,
    output logic         o_valid,
    input  logic         i_ready,
    output t_state_array o_state,
    input  logic         i_abort,
    output logic         o_busy
);

    localparam bit LEGAL = (G_NUM_SBOXES >= 1)
                        && (G_NUM_SBOXES <= 64)
                        && ((64 % G_NUM_SBOXES) == 0);
    localparam int K  = LEGAL ? 64 / G_NUM_SBOXES : 1;
    localparam int CW = (K > 1) ? $clog2(K) : 1;
    localparam logic [CW-1:0] LAST = CW'(K - 1);

    if (!LEGAL) begin : g_bad
        $error("G_NUM_SBOXES must be 1..64 and divide 64");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    t_state_array  work;
    t_state_array  work_nxt;
    logic          valid_q;
    logic          ready_q;
    logic          busy_q;

    logic [5:0] base;
    logic [5:0] cidx [G_NUM_SBOXES];
    logic [4:0] sin  [G_NUM_SBOXES];
    logic [4:0] sout [G_NUM_SBOXES];

    assign base = 6'(32'(cnt) * G_NUM_SBOXES);

    for (genvar j = 0; j < G_NUM_SBOXES; j++) begin : g_sb
        assign cidx[j] = base + 6'(j);
        assign sin[j]  = {work[0][cidx[j]], work[1][cidx[j]],
                          work[2][cidx[j]], work[3][cidx[j]],
                          work[4][cidx[j]]};
        sbox u_sbox (
            .i_x(sin[j]),
            .o_y(sout[j])
        );
    end

    // Write the selected columns back in place
    always_comb begin
        work_nxt = work;
        for (int j = 0; j < G_NUM_SBOXES; j++) begin
            for (int r = 0; r < 5; r++) begin
                work_nxt[r][cidx[j]] = sout[j][4-r];
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= S_IDLE;
            cnt     <= '0;
            work    <= '0;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
        end else if (i_abort) begin
            state   <= S_IDLE;
            cnt     <= '0;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (i_valid) begin
                        work    <= i_state;
                        cnt     <= '0;
                        state   <= S_BUSY;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                S_BUSY: begin
                    work <= work_nxt;
                    if (cnt == LAST) begin
                        cnt     <= '0;
                        state   <= S_DONE;
                        busy_q  <= 1'b0;
                        valid_q <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_DONE: begin
                    if (i_ready) begin
                        state   <= S_IDLE;
                        valid_q <= 1'b0;
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    valid_q <= 1'b0;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign o_valid = valid_q;
    assign o_ready = ready_q;
    assign o_busy  = busy_q;
    assign o_state = (G_OUT_REG || valid_q) ? work : '0;

endmodule

// File: tb/tb_substitution_layer_iter.sv
// Bench for substitution_layer_iter.
// Four instances (N=1,4,8,64) run in lockstep against a table model.
module tb_substitution_layer_iter;
    import ascon_pkg::*;

    localparam logic [4:0] SBOX [32] = '{
        5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
        5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
        5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
        5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
    };
    localparam int KK [4] = '{64, 16, 8, 1};

    logic         clk = 1'b0;
    logic         rst_n;
    logic         i_valid;
    logic         i_ready;
    logic         i_abort;
    t_state_array i_state;
    logic [3:0]   v;
    logic [3:0]   rd;
    logic [3:0]   bz;
    t_state_array st [4];

    int           n_chk = 0;
    int           n_err = 0;
    int           lat [4];
    t_state_array res [4];
    t_state_array s;
    t_state_array e;
    logic         any_v;

    always #5 clk = ~clk;

    substitution_layer_iter #(.G_NUM_SBOXES(1), .G_OUT_REG(1'b1)) u_n1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(rd[0]),
        .i_state(i_state), .o_valid(v[0]), .i_ready(i_ready),
        .o_state(st[0]), .i_abort(i_abort), .o_busy(bz[0]));
    substitution_layer_iter #(.G_NUM_SBOXES(4), .G_OUT_REG(1'b0)) u_n4 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(rd[1]),
        .i_state(i_state), .o_valid(v[1]), .i_ready(i_ready),
        .o_state(st[1]), .i_abort(i_abort), .o_busy(bz[1]));
    substitution_layer_iter #(.G_NUM_SBOXES(8), .G_OUT_REG(1'b1)) u_n8 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(rd[2]),
        .i_state(i_state), .o_valid(v[2]), .i_ready(i_ready),
        .o_state(st[2]), .i_abort(i_abort), .o_busy(bz[2]));
    substitution_layer_iter #(.G_NUM_SBOXES(64), .G_OUT_REG(1'b1)) u_n64 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(rd[3]),
        .i_state(i_state), .o_valid(v[3]), .i_ready(i_ready),
        .o_state(st[3]), .i_abort(i_abort), .o_busy(bz[3]));

    task automatic check(input string tag, input logic [319:0] got,
                         input logic [319:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic t_state_array ref_sub(input t_state_array x);
        t_state_array o;
        logic [4:0]   c;
        logic [4:0]   y;
        o = '0;
        for (int i = 0; i < 64; i++) begin
            c = {x[0][i], x[1][i], x[2][i], x[3][i], x[4][i]};
            y = SBOX[c];
            for (int r = 0; r < 5; r++) o[r][i] = y[4-r];
        end
        return o;
    endfunction

    function automatic t_state_array rand_state();
        t_state_array x;
        for (int r = 0; r < 5; r++) x[r] = {$urandom(), $urandom()};
        return x;
    endfunction

    task automatic issue(input t_state_array x, input string tag);
        bit seen [4];
        t_state_array exp;
        exp = ref_sub(x);
        i_state = x;
        i_valid = 1'b1;
        i_ready = 1'b0;
        @(negedge clk);
        i_valid = 1'b0;
        i_state = rand_state();
        for (int d = 0; d < 4; d++) begin
            seen[d] = 1'b0;
            lat[d]  = -1;
        end
        for (int n = 1; n <= 80; n++) begin
            if (n == 1) begin
                check({tag, "_busy8"}, 320'(bz[2]), 320'(1));
                check({tag, "_zero_n4"}, st[1], '0);
            end
            for (int d = 0; d < 4; d++) begin
                if (!seen[d] && v[d]) begin
                    seen[d] = 1'b1;
                    lat[d]  = n;
                    res[d]  = st[d];
                end
            end
            if (seen[0] && seen[1] && seen[2] && seen[3]) break;
            @(negedge clk);
            i_state = rand_state();
        end
        for (int d = 0; d < 4; d++) begin
            check($sformatf("%s_lat%0d", tag, d), 320'(lat[d]),
                  320'(1 + KK[d]));
            check($sformatf("%s_res%0d", tag, d), res[d], exp);
        end
    endtask

    task automatic release_out(input string tag);
        i_ready = 1'b1;
        @(negedge clk);
        i_ready = 1'b0;
        check({tag, "_ready"}, 320'(rd), 320'(4'hF));
        check({tag, "_valid"}, 320'(v), 320'(0));
    endtask

    initial begin
        rst_n   = 1'b0;
        i_valid = 1'b0;
        i_ready = 1'b0;
        i_abort = 1'b0;
        i_state = '0;
        @(negedge clk);
        check("rst_ready", 320'(rd), 320'(4'hF));
        check("rst_valid", 320'(v), 320'(0));
        check("rst_busy", 320'(bz), 320'(0));
        check("rst_state8", st[2], '0);
        rst_n = 1'b1;
        @(negedge clk);

        issue('0, "zeros");
        check("zeros_w2", 320'(res[2][2]), 320'(64'hFFFF_FFFF_FFFF_FFFF));
        check("zeros_w0134", 320'({res[2][0], res[2][1],
              res[2][3], res[2][4]}), 320'(0));
        release_out("zeros");

        s = '1;
        issue(s, "ones");
        check("ones_w1", 320'(res[2][1]), 320'(0));
        check("ones_w0234", 320'(&{res[2][0], res[2][2],
              res[2][3], res[2][4]}), 320'(1));
        e = ref_sub(s);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_state", st[2], e);
            check("hold_valid", 320'(v[2]), 320'(1));
            check("hold_ready", 320'(rd[2]), 320'(0));
        end
        release_out("ones");

        for (int t = 0; t < 6; t++) begin
            issue(rand_state(), $sformatf("rnd%0d", t));
            release_out("rnd");
        end

        s = rand_state();
        i_state = s;
        i_valid = 1'b1;
        @(negedge clk);
        i_valid = 1'b0;
        repeat (3) @(negedge clk);
        i_abort = 1'b1;
        @(negedge clk);
        i_abort = 1'b0;
        check("abort_ready", 320'(rd), 320'(4'hF));
        check("abort_busy", 320'(bz), 320'(0));
        any_v = 1'b0;
        for (int i = 0; i < 10; i++) begin
            any_v = any_v | (|v);
            @(negedge clk);
        end
        check("abort_novalid", 320'(any_v), 320'(0));
        issue(rand_state(), "post_abort");
        release_out("post_abort");

        i_state = rand_state();
        i_valid = 1'b1;
        @(negedge clk);
        i_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_ready", 320'(rd), 320'(4'hF));
        check("mid_rst_valid", 320'(v), 320'(0));
        check("mid_rst_busy", 320'(bz), 320'(0));
        check("mid_rst_state8", st[2], '0);
        check("mid_rst_state1", st[0], '0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        issue(rand_state(), "post_rst");
        release_out("post_rst");

        $display("Simulation finished: %0d checks, %0d errors",
                 n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/substitution_layer_iter.md
SUBSTITUTION_LAYER_ITER -- requirements
Module: substitution_layer_iter

Interface
REQ-001 SHALL have parameter G_NUM_SBOXES, default 8: S-boxes applied per cycle; legal values 1, 2, 4, 8, 16, 32, 64.
REQ-002 SHALL have parameter G_OUT_REG, default 1: 1 = o_state driven from the working register; 0 = identical timing, o_state additionally forced to zero while o_valid=0.
REQ-003 SHALL have port i_clk  input  1  single system clock, rising edge.
REQ-004 SHALL have port i_rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port i_valid  input  1  input state offered.
REQ-006 SHALL have port o_ready  output  1  block can accept an input state.
REQ-007 SHALL have port i_state  input  t_state_array  state to substitute (5 x 64 bits).
REQ-008 SHALL have port o_valid  output  1  substituted state available.
REQ-009 SHALL have port i_ready  input  1  downstream accepts o_state.
REQ-010 SHALL have port o_state  output  t_state_array  substituted state.
REQ-011 SHALL have port i_abort  input  1  synchronous abort of any operation in progress.
REQ-012 SHALL have port o_busy  output  1  high while in BUSY.

Function
REQ-013 SHALL define K = 64 / G_NUM_SBOXES passes; column i is the 5-bit word {s[0][i], s[1][i], s[2][i], s[3][i], s[4][i]}, with s[0] as MSB.
REQ-014 SHALL use an FSM with states IDLE, BUSY and DONE; o_ready=1 only in IDLE; o_valid=1 only in DONE.
REQ-015 SHALL, in IDLE with i_valid=1, load i_state into the working register, clear the pass counter, and go to BUSY.
REQ-016 SHALL, on each BUSY clock edge, replace columns [cnt*G_NUM_SBOXES +: G_NUM_SBOXES] with their S-box images in place, leave all other columns unchanged, and increment cnt.
REQ-017 SHALL, on the BUSY edge where cnt == K-1, go to DONE; cnt wraps to 0 at the same edge.
REQ-018 SHALL raise o_valid in cycle c+1+K for a handshake in cycle c; for G_NUM_SBOXES=64, o_valid SHALL rise in cycle c+2.
REQ-019 SHALL, in DONE, hold o_valid and o_state stable until i_ready=1, then return to IDLE on that edge; no new input is accepted in the same cycle.
REQ-020 SHALL ignore i_valid outside IDLE; i_state changes during BUSY or DONE SHALL NOT affect the result.
REQ-021 SHALL, when i_abort=1 at any edge, go to IDLE and clear cnt; i_abort SHALL have priority over all other transitions.
REQ-022 SHALL keep the working-register contents after an abort; the abort SHALL suppress o_valid.
REQ-023 SHALL size cnt as max(1, log2(K)) bits, so that K=1 needs no special-case logic.
REQ-024 SHALL produce o_state equal to the full 64-column combinational substitution of the accepted input, for every legal G_NUM_SBOXES.

Reset
REQ-025 SHALL, while i_rst_n=0, set the state to IDLE, cnt=0, working register to all zeros, o_valid=0, o_busy=0, o_ready=1, and o_state=0.
REQ-026 SHALL, when reset asserts mid-operation, discard the operation immediately (asynchronously); the first accept after reset release SHALL behave exactly as from power-up.

Structure
REQ-027 SHALL take t_state_array from ascon_pkg; the legal-width check and K SHALL be localparams in the module, with no package additions.
REQ-028 SHALL instantiate G_NUM_SBOXES copies of the existing sbox module, with their inputs selected by cnt through a column multiplexer.
REQ-029 SHALL stop elaboration with $error when 64 % G_NUM_SBOXES != 0 or G_NUM_SBOXES is outside 1..64.

Verification
REQ-030 SHALL cover: N=8, i_state all zeros -> after 8 busy cycles, o_state[2]=64'hFFFF_FFFF_FFFF_FFFF and the other words 0 (sbox(0x00)=0x04).
REQ-031 SHALL cover: N=8, i_state all ones -> o_state[0], [2], [3], [4] all ones and o_state[1]=0 (sbox(0x1F)=0x17); o_valid rises exactly 9 cycles after the accept cycle.
REQ-032 SHALL cover: N in {1, 4, 64}, random states -> result matches a combinational reference model; latency 1+K for each N.
REQ-033 SHALL cover: i_ready held low for 5 cycles in DONE -> o_state and o_valid stable, o_ready=0; i_ready=1 -> IDLE on the next edge, o_ready=1.
REQ-034 SHALL cover: i_abort pulsed on busy pass 3 with N=8 -> IDLE on the next edge, o_valid never asserts; a new input is then processed correctly.
REQ-035 SHALL cover: i_rst_n low for 1 cycle mid-BUSY -> all outputs at reset values immediately; i_state changes during BUSY -> no effect on the result.
